cook_sequencer: RTL

COOK_SEQUENCER -- requirements
Module: cook_sequencer

---
 rtl/microwave_pkg.sv | 28 ++
 rtl/press_detect.sv | 27 ++
 rtl/cook_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook sequencer: state codes,
// power limits and default timing parameters.
package microwave_pkg;

  // FSM state codes, also driven straight onto the state debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } cook_state_t;

  localparam logic [3:0] MAX_POWER        = 4'd10;
  localparam int         DEF_POWER_WINDOW = 10;
  localparam int         DEF_BEEP_TICKS   = 3;

  // Requested level 0 means "full power"; anything above MAX_POWER saturates.
  function automatic logic [3:0] sat_power(input logic [3:0] level);
    logic [3:0] result;
    if (level == 4'd0 || level > MAX_POWER) begin
      result = MAX_POWER;
    end else begin
      result = level;
    end
    return result;
  endfunction

endpackage

// File: rtl/press_detect.sv
// Registered falling-edge detector for an active-low push button.
// The button is sampled once, then compared with the previous sample; press is
// high for exactly one clk per press no matter how long the button is held.
module press_detect (
  input  logic clk,
  input  logic clear,
  input  logic btn_n,
  output logic press
);

  logic btn_q;
  logic btn_prev;

  // Two-deep button history; both stages read "released" after clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      btn_q    <= 1'b1;
      btn_prev <= 1'b1;
    end else begin
      btn_q    <= btn_n;
      btn_prev <= btn_q;
    end
  end

  assign press = btn_prev & ~btn_q;

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: IDLE/COOK/PAUSE/DONE control FSM with a duty-cycle
// power controller and a completion beeper.
//
// Handshakes: there is no valid/ready traffic here. power_load is a one-clk
// strobe accepted only in IDLE; timer_clr is a one-clk request to the timer;
// tick_1hz is a one-clk enable. All outputs are registered and reflect the
// state entered on the most recent clk edge.
module cook_sequencer
  import microwave_pkg::*;
#(
  parameter int POWER_WINDOW = DEF_POWER_WINDOW,
  parameter int BEEP_TICKS   = DEF_BEEP_TICKS
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       timer_zero,
  input  logic [3:0] power_level,
  input  logic       power_load,
  output logic       mag_on,
  output logic       timer_en,
  output logic       timer_clr,
  output logic       beep,
  output logic [1:0] state
);

  localparam int DUTY_W = (POWER_WINDOW > 1) ? $clog2(POWER_WINDOW) : 1;
  localparam int BEEP_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;

  localparam logic [DUTY_W-1:0] DUTY_LAST = DUTY_W'(POWER_WINDOW - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_TICKS - 1);

  logic start_press;
  logic stop_press;

  cook_state_t       cur_state;
  cook_state_t       state_nxt;
  logic [DUTY_W-1:0] duty_cnt;
  logic [DUTY_W-1:0] duty_nxt;
  logic [BEEP_W-1:0] beep_cnt;
  logic [BEEP_W-1:0] beep_nxt;
  logic [3:0]        power_reg;
  logic [3:0]        power_nxt;
  logic              clr_nxt;
  logic              mag_nxt;

  press_detect u_start_press (
    .clk   (clk),
    .clear (clear),
    .btn_n (startn),
    .press (start_press)
  );

  press_detect u_stop_press (
    .clk   (clk),
    .clear (clear),
    .btn_n (stopn),
    .press (stop_press)
  );

  // Next-state, counter and power-register decisions for the coming edge.
  always_comb begin
    state_nxt = cur_state;
    duty_nxt  = duty_cnt;
    beep_nxt  = beep_cnt;
    power_nxt = power_reg;
    clr_nxt   = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (power_load) begin
          power_nxt = sat_power(power_level);
        end
        if (start_press && door_closed && !timer_zero) begin
          state_nxt = ST_COOK;
          duty_nxt  = '0;
        end
      end
      ST_COOK: begin
        // The duty phase keeps running on the tick that ends cooking too.
        if (tick_1hz) begin
          duty_nxt = (duty_cnt == DUTY_LAST) ? '0 : duty_cnt + 1'b1;
        end
        // Reaching 00:00 outranks a simultaneous stop or door opening.
        if (timer_zero) begin
          state_nxt = ST_DONE;
          beep_nxt  = '0;
        end else if (!door_closed || stop_press) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop_press) begin
          state_nxt = ST_IDLE;
          clr_nxt   = 1'b1;
        end else if (start_press && door_closed) begin
          state_nxt = ST_COOK;
        end
      end
      ST_DONE: begin
        if (stop_press) begin
          state_nxt = ST_IDLE;
        end else if (tick_1hz) begin
          if (beep_cnt == BEEP_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            beep_nxt = beep_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Magnetron drive for the coming edge; door_closed is used directly so an
  // opening door turns the magnetron off on the very next edge.
  always_comb begin
    mag_nxt = (state_nxt == ST_COOK) && door_closed &&
              (32'(duty_nxt) < 32'(power_nxt));
  end

  // State, counters, power register and registered outputs; clear dominates.
  always_ff @(posedge clk) begin
    if (clear) begin
      cur_state <= ST_IDLE;
      duty_cnt  <= '0;
      beep_cnt  <= '0;
      power_reg <= MAX_POWER;
      mag_on    <= 1'b0;
      timer_en  <= 1'b0;
      timer_clr <= 1'b0;
      beep      <= 1'b0;
    end else begin
      cur_state <= state_nxt;
      duty_cnt  <= duty_nxt;
      beep_cnt  <= beep_nxt;
      power_reg <= power_nxt;
      mag_on    <= mag_nxt;
      timer_en  <= (state_nxt == ST_COOK);
      timer_clr <= clr_nxt;
      beep      <= (state_nxt == ST_DONE);
    end
  end

  assign state = cur_state;

endmodule
